sd_spi_sector_reader: RTL and testbench
=======================================

Name: sd_spi_sector_reader

Overview:
- SPI-mode SD/SDHC card front end that powers up and initialises the card, then reads 512-byte sectors on request.
- Each sector is streamed out as 256 16-bit words on an AXI-stream-like output with no backpressure.
- It replaces the separate init/read pair and their external MISO/CS/MOSI muxing with a single SPI master. It sits between the physical card pins and the sector consumer.

Parameters:
- SCK_HALF, default 1: sd_clk cycles per SCK half-period. The SCK frequency is sd_clk/(2*SCK_HALF).
- POWERUP_CLKS, default 80: number of SCK cycles sent with CS high and MOSI high before CMD0.
- RESP_TIMEOUT, default 64: number of bytes polled for R1 or the data token before a timeout.

Ports:
- sd_clk  in  1  system clock; all logic uses its rising edge.
- sd_rst_n  in  1  asynchronous active-low reset.
- sd_miso  in  1  card data out.
- sd_sck  out  1  SPI clock (registered divider output, idle low, mode 0).
- sd_cs_n  out  1  card chip select, active low.
- sd_mosi  out  1  card data in.
- sdinit_ok  out  1  high once initialisation completes; stays high until reset.
- addr_TVALID  in  1  one-cycle read request strobe.
- addr  in  32  sector number (SDHC block address), sampled when addr_TVALID is high.
- busy  out  1  high during initialisation or while a read is in progress.
- SectorData_TVALID  out  1  one-cycle strobe per output word.
- SectorData_TDATA  out  16  sector word.
- SectorData_TLAST  out  1  high together with the 256th word.

Behaviour:
- Reset values: sd_sck=0, sd_cs_n=1, sd_mosi=1, sdinit_ok=0, busy=1, all SectorData_* outputs 0. Reset mid-operation aborts immediately, and initialisation restarts after release.
- SPI timing:
  - MSB first.
  - sd_mosi changes only on the sd_clk edge where sd_sck falls (or on the first bit with SCK low).
  - sd_miso is sampled on the sd_clk edge where sd_sck rises.
  - A byte takes 8 SCK cycles. When idle, sd_mosi=1.
- Command frame: 6 bytes (cmd|0x40, arg[31:24..7:0], crc|1), sent with CS low and preceded by one 0xFF byte.
  - R1 polling: send 0xFF bytes until the received byte has bit7=0. After RESP_TIMEOUT bytes, treat it as a timeout.
  - After each command/response, raise CS and send 8 SCK cycles.
- Init FSM:
  - POWERUP: POWERUP_CLKS cycles with CS=1, MOSI=1.
  - CMD0: 40 00 00 00 00 95. Expect R1=0x01; otherwise retry CMD0.
  - CMD8: 48 00 00 01 AA 87. Expect R1=0x01, then read 4 more bytes; the last two must be 0x01 0xAA, otherwise go back to CMD0.
  - CMD55: 77 00 00 00 00 FF. Any R1 with bit7=0 is accepted.
  - ACMD41: 69 40 00 00 00 FF. R1=0x00 goes to DONE; R1=0x01 loops back to CMD55; any other value or a timeout goes back to CMD0.
  - DONE: sdinit_ok=1, busy=0, and the FSM enters IDLE.
- Read FSM:
  - In IDLE with sdinit_ok=1, addr_TVALID=1 latches addr and sets busy. Requests while busy or before sdinit_ok are ignored.
  - Send CMD17 (51 addr[31:0] FF) and expect R1=0x00.
  - Then poll for data token 0xFE for up to 8*RESP_TIMEOUT bytes.
  - Receive 512 bytes. Bytes 2k and 2k+1 form word k, with the even byte in TDATA[15:8] (big-endian).
  - SectorData_TVALID pulses for one sd_clk cycle on the cycle after the odd byte's last bit is sampled. TDATA holds its value until the next word. TLAST=1 only for k=255.
  - Then read 2 CRC bytes and discard them. Raise CS, send 8 SCK cycles, clear busy, return to IDLE.
  - If R1≠0x00 or the token times out: abort with no words output, raise CS, clear busy, return to IDLE.
- Sector reads occur only after sdinit_ok. Word count is exactly 256 per successful read.

Test Plan:
- Reset released with a compliant card model → sees ≥80 SCK cycles with CS=1, then CMD0, CMD8, CMD55, ACMD41 frames with exact bytes above; sdinit_ok rises after ACMD41 R1=0x00; busy falls.
- Card answers ACMD41 with 0x01 three times, then 0x00 → CMD55/ACMD41 pair sent 4 times; sdinit_ok=1.
- addr_TVALID pulse with addr=0 → MOSI frame 51 00 00 00 00 FF; card sector byte i = i[7:0] gives 256 TVALID pulses, word0=0x0001, word1=0x0203, word255=0xFEFF with TLAST=1.
- Second request addr=16 after first completes → CMD17 argument 0x00000010; another 256 words; addr_TVALID pulses during the read are ignored (single CMD17).
- Card never sends 0xFE → no TVALID, CS high, busy=0, next request accepted.
- Assert sd_rst_n mid-sector → outputs return to reset values immediately; on release init restarts from POWERUP.

Source files
------------

// File: rtl/sd_spi_sector_reader.sv
// SPI-mode SD/SDHC front end: powers up and initialises the card, then reads
// 512-byte sectors on request and streams them out as 256 big-endian 16-bit words.
// A single byte engine drives SCK/MOSI/MISO. One FSM sequences init and reads.
module sd_spi_sector_reader #(
  parameter int SCK_HALF     = 1,
  parameter int POWERUP_CLKS = 80,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic        sd_clk,
  input  logic        sd_rst_n,
  input  logic        sd_miso,
  output logic        sd_sck,
  output logic        sd_cs_n,
  output logic        sd_mosi,
  output logic        sdinit_ok,
  input  logic        addr_TVALID,
  input  logic [31:0] addr,
  output logic        busy,
  output logic        SectorData_TVALID,
  output logic [15:0] SectorData_TDATA,
  output logic        SectorData_TLAST
);

  localparam int HW        = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int PWR_BYTES = (POWERUP_CLKS + 7) / 8;

  typedef enum logic [3:0] {
    ST_PWR, ST_CMD, ST_R1, ST_R7, ST_TOK, ST_DATA, ST_CRC, ST_TAIL, ST_DONE, ST_IDLE
  } state_e;

  typedef enum logic [2:0] {
    C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD17
  } cmd_e;

  // ---------------------------------------------------------------------------
  // Byte engine (mode 0, MSB first)
  // ---------------------------------------------------------------------------
  logic          eng_act_q;
  logic [HW-1:0] div_q;
  logic          sck_q;
  logic          mosi_q;
  logic [2:0]    bit_q;
  logic [6:0]    tx_q;
  logic [7:0]    rx_q;
  logic          eng_start;
  logic [7:0]    eng_tx;
  logic          half_tick;
  logic          eng_done;  // edge where the 8th bit is sampled
  logic          eng_end;   // edge where SCK falls after the 8th bit
  logic [7:0]    eng_rx;

  assign half_tick = (div_q == HW'(SCK_HALF - 1));
  assign eng_done  = eng_act_q && half_tick && !sck_q && (bit_q == 3'd7);
  assign eng_end   = eng_act_q && half_tick &&  sck_q && (bit_q == 3'd7);
  assign eng_rx    = {rx_q[6:0], sd_miso};

  // Shift one byte: MOSI moves on SCK fall, MISO is captured on SCK rise.
  always_ff @(posedge sd_clk or negedge sd_rst_n) begin
    if (!sd_rst_n) begin
      eng_act_q <= 1'b0;
      div_q     <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b1;
      bit_q     <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
    end else if (!eng_act_q) begin
      if (eng_start) begin
        eng_act_q <= 1'b1;
        div_q     <= '0;
        bit_q     <= '0;
        mosi_q    <= eng_tx[7];
        tx_q      <= eng_tx[6:0];
      end
    end else if (half_tick) begin
      div_q <= '0;
      sck_q <= !sck_q;
      if (!sck_q) begin
        rx_q <= eng_rx;
      end else if (bit_q == 3'd7) begin
        eng_act_q <= 1'b0;
        mosi_q    <= 1'b1;
      end else begin
        bit_q  <= bit_q + 3'd1;
        mosi_q <= tx_q[6];
        tx_q   <= {tx_q[5:0], 1'b0};
      end
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d, ret_q, ret_d;
  cmd_e        cmd_q, cmd_d;
  logic [9:0]  bcnt_q, bcnt_d;
  logic [15:0] to_q, to_d;
  logic        ok_q, ok_d;
  logic [31:0] addr_q, addr_d;
  logic        init_q, init_d;
  logic [5:0]  cmd_idx;
  logic [31:0] cmd_arg;
  logic [7:0]  cmd_crc;
  logic [7:0]  frame_byte;

  // Command frame byte for the current position: 0xFF lead-in, then 6 bytes.
  always_comb begin
    cmd_idx = 6'd0;
    cmd_arg = 32'd0;
    cmd_crc = 8'hFF;
    case (cmd_q)
      C_CMD0:   cmd_crc = 8'h95;
      C_CMD8:   begin cmd_idx = 6'd8;  cmd_arg = 32'h0000_01AA; cmd_crc = 8'h87; end
      C_CMD55:  cmd_idx = 6'd55;
      C_ACMD41: begin cmd_idx = 6'd41; cmd_arg = 32'h4000_0000; end
      C_CMD17:  begin cmd_idx = 6'd17; cmd_arg = addr_q; end
      default:  ;
    endcase
    case (bcnt_q[2:0])
      3'd1:    frame_byte = {2'b01, cmd_idx};
      3'd2:    frame_byte = cmd_arg[31:24];
      3'd3:    frame_byte = cmd_arg[23:16];
      3'd4:    frame_byte = cmd_arg[15:8];
      3'd5:    frame_byte = cmd_arg[7:0];
      3'd6:    frame_byte = cmd_crc;
      default: frame_byte = 8'hFF;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge sd_clk or negedge sd_rst_n) begin
    if (!sd_rst_n) begin
      state_q <= ST_PWR;
      ret_q   <= ST_IDLE;
      cmd_q   <= C_CMD0;
      bcnt_q  <= '0;
      to_q    <= '0;
      ok_q    <= 1'b0;
      addr_q  <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cmd_q   <= cmd_d;
      bcnt_q  <= bcnt_d;
      to_q    <= to_d;
      ok_q    <= ok_d;
      addr_q  <= addr_d;
      init_q  <= init_d;
    end
  end

  // Next-state logic; transitions happen when a byte fully ends so CS only
  // moves with SCK low.
  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cmd_d     = cmd_q;
    bcnt_d    = bcnt_q;
    to_d      = to_q;
    ok_d      = ok_q;
    addr_d    = addr_q;
    init_d    = init_q;
    eng_tx    = 8'hFF;
    eng_start = (state_q != ST_IDLE) && (state_q != ST_DONE) && !eng_act_q;
    case (state_q)
      ST_PWR: if (eng_end) begin
        bcnt_d = bcnt_q + 10'd1;
        if (bcnt_q == 10'(PWR_BYTES - 1)) begin
          bcnt_d  = '0;
          cmd_d   = C_CMD0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        eng_tx = frame_byte;
        if (eng_end) begin
          bcnt_d = bcnt_q + 10'd1;
          if (bcnt_q == 10'd6) begin
            bcnt_d  = '0;
            to_d    = '0;
            state_d = ST_R1;
          end
        end
      end
      ST_R1: if (eng_end) begin
        if (!rx_q[7]) begin
          state_d = ST_TAIL;
          ret_d   = ST_CMD;
          case (cmd_q)
            C_CMD0:  cmd_d = (rx_q == 8'h01) ? C_CMD8 : C_CMD0;
            C_CMD8:  if (rx_q == 8'h01) begin
                       state_d = ST_R7;
                       bcnt_d  = '0;
                     end else begin
                       cmd_d = C_CMD0;
                     end
            C_CMD55: cmd_d = C_ACMD41;
            C_ACMD41: begin
              if (rx_q == 8'h00)      ret_d = ST_DONE;
              else if (rx_q == 8'h01) cmd_d = C_CMD55;
              else                    cmd_d = C_CMD0;
            end
            default: if (rx_q == 8'h00) begin
                       state_d = ST_TOK;
                       to_d    = '0;
                     end else begin
                       ret_d = ST_IDLE;
                     end
          endcase
        end else if (to_q == 16'(RESP_TIMEOUT - 1)) begin
          state_d = ST_TAIL;
          if (cmd_q == C_CMD17) begin
            ret_d = ST_IDLE;
          end else begin
            ret_d = ST_CMD;
            cmd_d = C_CMD0;
          end
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      ST_R7: if (eng_end) begin
        bcnt_d = bcnt_q + 10'd1;
        if (bcnt_q == 10'd2) ok_d = (rx_q == 8'h01);
        if (bcnt_q == 10'd3) begin
          bcnt_d  = '0;
          state_d = ST_TAIL;
          ret_d   = ST_CMD;
          cmd_d   = (ok_q && rx_q == 8'hAA) ? C_CMD55 : C_CMD0;
        end
      end
      ST_TOK: if (eng_end) begin
        if (rx_q == 8'hFE) begin
          state_d = ST_DATA;
          bcnt_d  = '0;
        end else if (to_q == 16'(8 * RESP_TIMEOUT - 1)) begin
          state_d = ST_TAIL;
          ret_d   = ST_IDLE;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      ST_DATA: if (eng_end) begin
        bcnt_d = bcnt_q + 10'd1;
        if (bcnt_q == 10'd511) begin
          bcnt_d  = '0;
          state_d = ST_CRC;
        end
      end
      ST_CRC: if (eng_end) begin
        bcnt_d = bcnt_q + 10'd1;
        if (bcnt_q == 10'd1) begin
          bcnt_d  = '0;
          state_d = ST_TAIL;
          ret_d   = ST_IDLE;
        end
      end
      ST_TAIL: if (eng_end) begin
        state_d = ret_q;
        bcnt_d  = '0;
        to_d    = '0;
      end
      ST_DONE: begin
        init_d  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_IDLE: if (addr_TVALID && init_q) begin
        addr_d  = addr;
        cmd_d   = C_CMD17;
        bcnt_d  = '0;
        state_d = ST_CMD;
      end
      default: state_d = ST_PWR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sector word output
  // ---------------------------------------------------------------------------
  logic [7:0]  hi_q;
  logic        tvalid_q;
  logic        tlast_q;
  logic [15:0] tdata_q;

  // Pair bytes into words as soon as the odd byte's last bit is captured.
  always_ff @(posedge sd_clk or negedge sd_rst_n) begin
    if (!sd_rst_n) begin
      hi_q     <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
    end else begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      if (eng_done && state_q == ST_DATA) begin
        if (!bcnt_q[0]) begin
          hi_q <= eng_rx;
        end else begin
          tvalid_q <= 1'b1;
          tdata_q  <= {hi_q, eng_rx};
          tlast_q  <= (bcnt_q == 10'd511);
        end
      end
    end
  end

  assign sd_sck            = sck_q;
  assign sd_mosi           = mosi_q;
  assign sd_cs_n           = !(state_q inside {ST_CMD, ST_R1, ST_R7, ST_TOK, ST_DATA, ST_CRC});
  assign sdinit_ok         = init_q;
  assign busy              = (state_q != ST_IDLE);
  assign SectorData_TVALID = tvalid_q;
  assign SectorData_TDATA  = tdata_q;
  assign SectorData_TLAST  = tlast_q;

endmodule

// File: tb/tb_sd_spi_sector_reader.sv
// Bench for sd_spi_sector_reader: a behavioural SPI card answers commands,
// expected command frames and sector words are queued by the stimulus and
// popped by the card/monitor process as the DUT produces them.
module tb_sd_spi_sector_reader;

  logic        sd_clk = 1'b0;
  logic        sd_rst_n = 1'b1;
  logic        sd_miso;
  logic        sd_sck, sd_cs_n, sd_mosi, sdinit_ok, busy;
  logic        addr_TVALID;
  logic [31:0] addr;
  logic        SectorData_TVALID, SectorData_TLAST;
  logic [15:0] SectorData_TDATA;

  sd_spi_sector_reader #(.SCK_HALF(1), .POWERUP_CLKS(80), .RESP_TIMEOUT(64)) dut (
    .sd_clk(sd_clk), .sd_rst_n(sd_rst_n), .sd_miso(sd_miso),
    .sd_sck(sd_sck), .sd_cs_n(sd_cs_n), .sd_mosi(sd_mosi), .sdinit_ok(sdinit_ok),
    .addr_TVALID(addr_TVALID), .addr(addr), .busy(busy),
    .SectorData_TVALID(SectorData_TVALID), .SectorData_TDATA(SectorData_TDATA),
    .SectorData_TLAST(SectorData_TLAST)
  );

  always #5 sd_clk = !sd_clk;

  int n_cmp, n_err;

  logic [47:0] exp_cmd[$];
  logic [16:0] exp_word[$];
  logic [7:0]  resp[$];

  // card configuration (written by stimulus only)
  int acmd_busy_cfg;
  bit no_token;

  // card / monitor state (written by the card process only)
  logic        sck_prev;
  int          bits;
  logic [7:0]  cur, rx_sh;
  bit          in_frame, seen_cs;
  int          fidx, ack_cnt, pwr_clks, word_cnt;
  logic [47:0] frame;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic card_byte(input logic [7:0] b);
    logic [47:0] e;
    if (!in_frame) begin
      if (!sd_cs_n && b[7:6] == 2'b01) begin
        in_frame = 1;
        fidx     = 1;
        frame    = {40'd0, b};
      end
    end else begin
      frame = {frame[39:0], b};
      fidx++;
      if (fidx == 6) begin
        in_frame = 0;
        n_cmp++;
        if (exp_cmd.size() == 0) begin
          n_err++;
          $display("FAIL cmd_unexpected: got frame 0x%012h, expected none", frame);
        end else begin
          n_cmp--;
          e = exp_cmd.pop_front();
          chk("cmd_frame", frame, e);
        end
        resp.push_back(8'hFF);
        case (frame[45:40])
          6'd0:  resp.push_back(8'h01);
          6'd8:  begin
            resp.push_back(8'h01); resp.push_back(8'h00); resp.push_back(8'h00);
            resp.push_back(8'h01); resp.push_back(8'hAA);
          end
          6'd55: resp.push_back(8'h01);
          6'd41: begin
            resp.push_back(ack_cnt < acmd_busy_cfg ? 8'h01 : 8'h00);
            ack_cnt++;
          end
          6'd17: begin
            resp.push_back(8'h00);
            if (!no_token) begin
              resp.push_back(8'hFF); resp.push_back(8'hFF); resp.push_back(8'hFE);
              for (int i = 0; i < 512; i++) resp.push_back(8'(i) + frame[15:8]);
              resp.push_back(8'h12); resp.push_back(8'h34);
            end
          end
          default: resp.push_back(8'h04);
        endcase
      end
    end
  endtask

  // SPI card model and sector-word monitor, evaluated mid-cycle.
  always @(negedge sd_clk) begin
    if (!sd_rst_n) begin
      sck_prev = 0; bits = 0; cur = 8'hFF; sd_miso = 1'b1;
      in_frame = 0; fidx = 0; ack_cnt = 0; pwr_clks = 0; seen_cs = 0;
      resp.delete();
    end else begin
      if (sd_sck && !sck_prev) begin
        if (!sd_cs_n) seen_cs = 1;
        else if (!seen_cs) pwr_clks++;
        rx_sh = {rx_sh[6:0], sd_mosi};
        bits++;
        if (bits == 8) begin
          bits = 0;
          card_byte(rx_sh);
        end
      end else if (!sd_sck && sck_prev) begin
        if (bits == 0) cur = (resp.size() != 0) ? resp.pop_front() : 8'hFF;
        sd_miso = cur[3'(7 - bits)];
      end
      sck_prev = sd_sck;
      if (SectorData_TVALID) begin
        word_cnt++;
        if (exp_word.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL word_unexpected: got 0x%0h last=%0b, expected none",
                   SectorData_TDATA, SectorData_TLAST);
        end else begin
          chk("sector_word", {SectorData_TLAST, SectorData_TDATA}, exp_word.pop_front());
        end
      end
    end
  end

  task automatic push_init(input int acmd_busy);
    exp_cmd.push_back(48'h40_00000000_95);
    exp_cmd.push_back(48'h48_000001AA_87);
    for (int i = 0; i <= acmd_busy; i++) begin
      exp_cmd.push_back(48'h77_00000000_FF);
      exp_cmd.push_back(48'h69_40000000_FF);
    end
  endtask

  task automatic push_read(input logic [31:0] a, input bit with_words);
    exp_cmd.push_back({8'h51, a, 8'hFF});
    if (with_words)
      for (int k = 0; k < 256; k++)
        exp_word.push_back({k == 255, 8'(2 * k) + a[7:0], 8'(2 * k + 1) + a[7:0]});
  endtask

  task automatic request(input logic [31:0] a);
    addr = a; addr_TVALID = 1'b1;
    @(negedge sd_clk);
    addr_TVALID = 1'b0; addr = '0;
  endtask

  task automatic wait_init(input string nm);
    for (int i = 0; i < 20000 && !sdinit_ok; i++) @(negedge sd_clk);
    chk(nm, sdinit_ok, 1'b1);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 20000 && busy; i++) @(negedge sd_clk);
    chk(nm, busy, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sck"}, sd_sck, 1'b0);
    chk({tag, "_cs_n"}, sd_cs_n, 1'b1);
    chk({tag, "_mosi"}, sd_mosi, 1'b1);
    chk({tag, "_init_ok"}, sdinit_ok, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_tvalid"}, SectorData_TVALID, 1'b0);
    chk({tag, "_tdata"}, SectorData_TDATA, 16'h0000);
    chk({tag, "_tlast"}, SectorData_TLAST, 1'b0);
  endtask

  initial begin
    int base;
    n_cmp = 0; n_err = 0;
    addr_TVALID = 1'b0; addr = '0;
    acmd_busy_cfg = 3; no_token = 0;
    #1 sd_rst_n = 1'b0;
    repeat (3) @(negedge sd_clk);
    chk_reset_vals("reset");

    // init with ACMD41 busy three times; an early request must be ignored
    push_init(3);
    sd_rst_n = 1'b1;
    repeat (60) @(negedge sd_clk);
    request(32'h99);
    wait_init("init_done");
    chk("init_busy_low", busy, 1'b0);
    chk("powerup_clks_ge_80", pwr_clks >= 80, 1'b1);
    chk("init_frames_left", exp_cmd.size(), 0);

    // sector 0: bytes i -> words 0x0001 .. 0xFEFF
    base = word_cnt;
    push_read(32'h0, 1);
    request(32'h0);
    chk("read0_busy", busy, 1'b1);
    wait_idle("read0_idle");
    chk("read0_words", word_cnt - base, 256);
    chk("read0_words_left", exp_word.size(), 0);
    chk("read0_cs_n", sd_cs_n, 1'b1);

    // sector 16 with extra strobes during the read
    base = word_cnt;
    push_read(32'h10, 1);
    request(32'h10);
    chk("read16_busy", busy, 1'b1);
    repeat (300) @(negedge sd_clk);
    request(32'h55);
    repeat (2000) @(negedge sd_clk);
    request(32'h66);
    wait_idle("read16_idle");
    chk("read16_words", word_cnt - base, 256);
    chk("read16_words_left", exp_word.size(), 0);
    chk("read16_frames_left", exp_cmd.size(), 0);

    // data token never arrives
    no_token = 1;
    base = word_cnt;
    push_read(32'h5, 0);
    request(32'h5);
    chk("notok_busy", busy, 1'b1);
    wait_idle("notok_idle");
    chk("notok_words", word_cnt - base, 0);
    chk("notok_cs_n", sd_cs_n, 1'b1);
    no_token = 0;

    // next request accepted, then reset in the middle of the sector
    base = word_cnt;
    push_read(32'h7, 1);
    request(32'h7);
    chk("read7_busy", busy, 1'b1);
    for (int i = 0; i < 20000 && (word_cnt - base) < 100; i++) @(negedge sd_clk);
    chk("read7_words_before_reset", (word_cnt - base) >= 100, 1'b1);
    #2 sd_rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    exp_word.delete();
    chk("midreset_frames_left", exp_cmd.size(), 0);
    exp_cmd.delete();
    repeat (3) @(negedge sd_clk);

    acmd_busy_cfg = 0;
    push_init(0);
    sd_rst_n = 1'b1;
    wait_init("reinit_done");
    chk("reinit_busy_low", busy, 1'b0);
    chk("reinit_powerup_ge_80", pwr_clks >= 80, 1'b1);
    chk("reinit_frames_left", exp_cmd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
